// File: rtl/ram_block_responder.sv
// ram_block_responder: backing RAM for the cache miss path; serves aligned block
// reads after a fixed latency and single-word writes while idle.
module ram_block_responder #(
   parameter int RAM_ADDRESS_BITS = 10,
   parameter int DATA_BITS        = 32,
   parameter int BLOCK_BITS       = 2,
   parameter int READ_LATENCY     = 4,
   parameter int GUARD_CYCLES     = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [RAM_ADDRESS_BITS-1:0] address,
   input  logic                        read_en,
   input  logic [DATA_BITS-1:0]        write_data,
   input  logic                        write_en,
   output logic                        ram_valid,
   output logic [DATA_BITS-1:0]        ram_data [2**BLOCK_BITS-1:0],
   output logic                        busy,
   output logic                        write_dropped
);
   localparam int BLOCK_SIZE = 2**BLOCK_BITS;
   localparam int LW = $clog2(READ_LATENCY + 1);
   localparam int GW = $clog2(GUARD_CYCLES + 2);

   typedef enum logic [1:0] {IDLE, WAIT, RESP, GUARD} state_t;

   state_t                      state;
   logic [LW-1:0]               cnt;
   logic [GW-1:0]               gcnt;
   logic [RAM_ADDRESS_BITS-1:0] base;
   logic [RAM_ADDRESS_BITS-1:0] rd_base;
   logic                        accept;
   logic                        load;
   logic [DATA_BITS-1:0]        mem [2**RAM_ADDRESS_BITS];

   // Simulation model contents: each word holds its own address.
   initial for (int i = 0; i < 2**RAM_ADDRESS_BITS; i++) mem[i] = DATA_BITS'(i);

   assign accept  = state == IDLE && read_en && !write_en;
   assign rd_base = state == IDLE ? address & ~RAM_ADDRESS_BITS'(BLOCK_SIZE - 1) : base;
   assign load    = (accept && READ_LATENCY == 1) || (state == WAIT && cnt == LW'(READ_LATENCY));
   assign busy    = state != IDLE;

   always_ff @(posedge clk)
      if (!reset && state == IDLE && write_en) mem[address] <= write_data;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         gcnt          <= '0;
         base          <= '0;
         ram_valid     <= 1'b0;
         write_dropped <= 1'b0;
         for (int k = 0; k < BLOCK_SIZE; k++) ram_data[k] <= '0;
      end else begin
         if (write_en && state != IDLE) write_dropped <= 1'b1;
         if (load) begin
            ram_valid <= 1'b1;
            for (int k = 0; k < BLOCK_SIZE; k++) ram_data[k] <= mem[rd_base | RAM_ADDRESS_BITS'(k)];
         end else if (state == RESP) begin
            ram_valid <= 1'b0;
            for (int k = 0; k < BLOCK_SIZE; k++) ram_data[k] <= '0;
         end
         case (state)
            IDLE: if (accept) begin
               base  <= rd_base;
               cnt   <= LW'(1);
               state <= READ_LATENCY == 1 ? RESP : WAIT;
            end
            WAIT: begin
               cnt   <= cnt + LW'(1);
               state <= load ? RESP : WAIT;
            end
            RESP: begin
               gcnt  <= '0;
               state <= GUARD_CYCLES == 0 ? IDLE : GUARD;
            end
            default: begin
               gcnt  <= gcnt + GW'(1);
               state <= gcnt == GW'(GUARD_CYCLES - 1) ? IDLE : GUARD;
            end
         endcase
      end
endmodule

// File: tb/tb_ram_block_responder.sv
// tb_ram_block_responder: table-driven and sequence checks of block reads, writes,
// guard timing, dropped writes and mid-read reset, with a pulse scoreboard.
module tb_ram_block_responder;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  address = '0;
   logic        read_en = 1'b0;
   logic [31:0] write_data = '0;
   logic        write_en = 1'b0;
   logic        ram_valid;
   logic [31:0] ram_data [3:0];
   logic        busy;
   logic        write_dropped;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct { int cyc; logic [31:0] d [4]; } exp_t;
   typedef struct { bit wr; logic [9:0] a; logic [31:0] wd; logic [31:0] d [4]; } vec_t;

   exp_t sbq [$];
   exp_t e;
   vec_t tbl [9];

   ram_block_responder dut (
      .clk(clk), .reset(reset), .address(address), .read_en(read_en),
      .write_data(write_data), .write_en(write_en), .ram_valid(ram_valid),
      .ram_data(ram_data), .busy(busy), .write_dropped(write_dropped)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Every negedge: pulses must match the scoreboard head in time and data, and
   // ram_data must be zero whenever ram_valid is low.
   always @(negedge clk) begin
      if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
         e = sbq.pop_front();
         chk("missed_pulse", 32'(cyc), 32'(e.cyc));
      end
      if (ram_valid) begin
         if (sbq.size() == 0) chk("unexpected_pulse", 32'(ram_valid), 32'd0);
         else begin
            e = sbq.pop_front();
            chk("pulse_time", 32'(cyc), 32'(e.cyc));
            for (int k = 0; k < 4; k++) chk("ram_data", ram_data[k], e.d[k]);
         end
      end else
         for (int k = 0; k < 4; k++) chk("idle_data", ram_data[k], 32'd0);
   end

   task automatic push_exp(input int c, input logic [31:0] d [4]);
      exp_t x;
      x.cyc = c;
      x.d = d;
      sbq.push_back(x);
   endtask

   task automatic wait_idle(input int exp_len);
      int n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (exp_len >= 0) chk("busy_len", 32'(n), 32'(exp_len));
      else chk("busy_timeout", 32'(busy), 32'd0);
   endtask

   task automatic wr(input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; write_data = d; write_en = 1'b1;
      @(negedge clk);
      write_en = 1'b0;
   endtask

   task automatic rd(input logic [9:0] a, input logic [31:0] d [4]);
      @(negedge clk);
      address = a; read_en = 1'b1;
      push_exp(cyc + 5, d);
      @(negedge clk);
      read_en = 1'b0;
      wait_idle(7);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{0, 10'h013, 32'h0, '{32'h10, 32'h11, 32'h12, 32'h13}};
      tbl[1] = '{1, 10'h0A5, 32'hDEADBEEF, '{32'h0, 32'h0, 32'h0, 32'h0}};
      tbl[2] = '{0, 10'h0A4, 32'h0, '{32'hA4, 32'hDEADBEEF, 32'hA6, 32'hA7}};
      tbl[3] = '{0, 10'h3FF, 32'h0, '{32'h3FC, 32'h3FD, 32'h3FE, 32'h3FF}};
      tbl[4] = '{0, 10'h000, 32'h0, '{32'h0, 32'h1, 32'h2, 32'h3}};
      tbl[5] = '{1, 10'h3FC, 32'h12345678, '{32'h0, 32'h0, 32'h0, 32'h0}};
      tbl[6] = '{0, 10'h3FE, 32'h0, '{32'h12345678, 32'h3FD, 32'h3FE, 32'h3FF}};
      tbl[7] = '{1, 10'h0A5, 32'hCAFEF00D, '{32'h0, 32'h0, 32'h0, 32'h0}};
      tbl[8] = '{0, 10'h0A7, 32'h0, '{32'hA4, 32'hCAFEF00D, 32'hA6, 32'hA7}};

      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(ram_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_dropped", 32'(write_dropped), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 9; i++)
         if (tbl[i].wr) wr(tbl[i].a, tbl[i].wd);
         else rd(tbl[i].a, tbl[i].d);

      // Held read_en: pulses at E0+4 and E0+12 only.
      @(negedge clk);
      address = 10'h020; read_en = 1'b1;
      push_exp(cyc + 5, '{32'h20, 32'h21, 32'h22, 32'h23});
      push_exp(cyc + 13, '{32'h20, 32'h21, 32'h22, 32'h23});
      repeat (14) @(negedge clk);
      read_en = 1'b0;
      wait_idle(-1);

      // Simultaneous read and write in IDLE: write first, read accepted next edge.
      @(negedge clk);
      address = 10'h031; write_data = 32'h55; read_en = 1'b1; write_en = 1'b1;
      @(negedge clk);
      write_en = 1'b0;
      push_exp(cyc + 5, '{32'h30, 32'h55, 32'h32, 32'h33});
      @(negedge clk);
      read_en = 1'b0;
      wait_idle(-1);

      // Write during WAIT is dropped and flagged.
      @(negedge clk);
      address = 10'h040; read_en = 1'b1;
      push_exp(cyc + 5, '{32'h40, 32'h41, 32'h42, 32'h43});
      @(negedge clk);
      read_en = 1'b0;
      address = 10'h002; write_data = 32'h77; write_en = 1'b1;
      @(negedge clk);
      write_en = 1'b0;
      chk("dropped_set", 32'(write_dropped), 32'd1);
      wait_idle(-1);
      chk("dropped_hold", 32'(write_dropped), 32'd1);
      rd(10'h000, '{32'h0, 32'h1, 32'h2, 32'h3});
      chk("dropped_hold2", 32'(write_dropped), 32'd1);

      // Reset two edges into a read: no stale pulse, memory kept.
      wr(10'h100, 32'hABCD0001);
      @(negedge clk);
      address = 10'h100; read_en = 1'b1;
      @(negedge clk);
      read_en = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(ram_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_dropped", 32'(write_dropped), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      rd(10'h102, '{32'hABCD0001, 32'h101, 32'h102, 32'h103});

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
